serial_sub_ctrl: RTL and testbench
==================================

Name: serial_sub_ctrl

Overview:
Bit-serial N-bit subtractor sequencer. It computes a - b one bit per clock, LSB first, using a single 1-bit subtract cell: half-subtractor logic plus a registered borrow, which makes a full subtractor in time. It provides a start/done handshake so wider subtractions can run on minimal gate-level hardware. It sits between a requesting controller and the gate-level subtractor cells.

Parameters:
N, 4, operand width in bits; legal N >= 2.
CW, $clog2(N), bit-cycle counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only in IDLE.
a  input  N  minuend; captured on accepted start.
b  input  N  subtrahend; captured on accepted start.
busy  output  1  high while in RUN or DONE.
done  output  1  one-cycle pulse; result valid.
diff  output  N  registered result, a - b mod 2^N.
borrow  output  1  registered final borrow-out; 1 when a < b unsigned.

Behaviour:
- Reset: state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift registers, borrow flop and counter all cleared.
- Reset asserted mid-operation aborts the operation on that edge. No done pulse is produced. The partial result is discarded and diff/borrow are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> capture a into sa and b into sb, clear br and cnt, clear internal result shift register sr, go to RUN.
  - start=0 -> stay in IDLE.
- RUN, each cycle, using bit0 of sa and sb:
  - d = sa0 ^ sb0 ^ br
  - br_next = (~sa0 & sb0) | (~(sa0 ^ sb0) & br)
  - sa and sb shift right by 1; sr shifts right with d inserted at the MSB.
  - cnt increments. When cnt == N-1, the final bit is processed on this edge and the state goes to DONE.
  - On that same edge, diff <= {d, sr[N-1:1]} and borrow <= br_next.
- DONE: done=1 for exactly one cycle, busy=1, then go to IDLE unconditionally.
- Latency: start sampled at edge E0.
  - RUN occupies cycles E0+1 .. E0+N.
  - diff/borrow update at edge E0+N.
  - done is high during the cycle after E0+N.
  - Next start can be accepted at edge E0+N+2.
- start while busy=1 (RUN or DONE) is ignored; no queuing.
- diff/borrow hold their value from completion until the next completion or reset. They never show partial results.
- a and b may change freely after the accepting edge; they do not affect the operation in flight.
- Arithmetic wraps modulo 2^N. Worked example: a=0, b=1 -> diff = all ones, borrow = 1.

Optional Feature:
Macro SERIAL_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), registered at completion alongside diff.
  - ovf = (a_msb != b_msb) && (diff_msb != a_msb), i.e. signed two's-complement overflow of a - b.
  - a_msb and b_msb come from the captured operands.
  - ovf resets to 0 and holds like diff.
- Undefined: no ovf port, no extra logic; behaviour otherwise identical.

Test Plan:
- N=4, a=9, b=5, pulse start -> busy high next cycle; done pulses 5 cycles after the start edge; diff=4, borrow=0.
- N=4, a=5, b=9 -> diff=4'hC, borrow=1. Then a=0, b=0 -> diff=0, borrow=0. Then a=15, b=15 -> diff=0, borrow=0.
- Start an operation (a=7, b=2), then hold start=1 with a=1, b=3 during RUN -> single done pulse, diff=5, borrow=0. The second request is not executed; a later clean start with a=1, b=3 gives diff=4'hE, borrow=1.
- Begin a=12, b=3; assert rst at the 2nd RUN cycle -> state=IDLE, busy=0, diff=0, borrow=0, no done pulse. A new start with a=12, b=3 gives diff=9.
- Back-to-back: restart on the first cycle where busy=0 -> accepted; 2nd result correct; exactly one done per operation.
- SERIAL_SUB_OVF_EN defined, N=4:
  - a=8 (-8), b=1 -> diff=7, ovf=1.
  - a=3, b=2 -> diff=1, ovf=0.
  - a=7, b=15 (-1) -> diff=8, ovf=1.

Source files
------------

// File: rtl/serial_sub_ctrl.sv
// Bit-serial N-bit subtractor sequencer: computes a - b one bit per clock, LSB first, with start/done handshake.
// Optional macro SERIAL_SUB_OVF_EN adds a registered signed-overflow output (ovf).
module serial_sub_ctrl #(
  parameter int N  = 4,
  localparam int CW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [N-1:0]  r_sr;
  logic          r_br;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_diff;
  logic          r_borrow;
  logic          w_d;
  logic          w_br_next;
  logic          w_last;

`ifdef SERIAL_SUB_OVF_EN
  logic          r_a_msb;
  logic          r_b_msb;
  logic          r_ovf;
  assign ovf = r_ovf;
`endif

  // One full-subtractor step built from the half-subtractor on bit 0 plus the stored borrow.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_d          = r_sa[0] ^ r_sb[0] ^ r_br;
    w_br_next    = (~r_sa[0] & r_sb[0]) | (~(r_sa[0] ^ r_sb[0]) & r_br);
    w_last       = (r_cnt == CW'(N - 1));
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state  <= S_IDLE;
      r_sa     <= '0;
      r_sb     <= '0;
      r_sr     <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_ovf    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
`endif
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sr  <= {w_d, r_sr[N-1:1]};
          r_br  <= w_br_next;
          r_cnt <= r_cnt + CW'(1);
          // Outputs only change on the final bit, so partial results are never visible.
          if (w_last) begin
            r_diff   <= {w_d, r_sr[N-1:1]};
            r_borrow <= w_br_next;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf    <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (N=4): stimulus pushes expected results, a monitor pops on done.
module tb_serial_sub_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_sub_ctrl #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];
  int   total    = 0;
  int   bad      = 0;
  int   done_cnt = 0;
  int   exp_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual=1 expected=0");
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("diff", 32'(diff), 32'(e.diff));
        check("borrow", 32'(borrow), 32'(e.borrow));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf), 32'(e.ovf));
`endif
      end
    end
  end

  // Issue start with the given operands and push the expected result; returns after the start edge.
  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib,
                       input logic [N-1:0] ed, input logic eb, input logic eo);
    exp_t e;
    @(negedge clk);
    check("idle_before_start", 32'(busy), 32'd0);
    a     = ia;
    b     = ib;
    start = 1'b1;
    e.diff = ed; e.borrow = eb; e.ovf = eo;
    sbq.push_back(e);
    exp_done++;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = N'($urandom);
    b     = N'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  // Bounded wait for done; it must arrive in the cycle after edge E0+N.
  task automatic wait_done();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 20);
    check("done_latency", 32'(k), 32'(N + 1));
  endtask

  task automatic run_op(input logic [N-1:0] ia, input logic [N-1:0] ib,
                        input logic [N-1:0] ed, input logic eb, input logic eo);
    issue(ia, ib, ed, eb, eo);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;

    // Basic vectors; each restarts on the first idle cycle (back-to-back).
    run_op(4'd9,  4'd5,  4'd4,  1'b0, 1'b1);
    run_op(4'd5,  4'd9,  4'hC,  1'b1, 1'b1);
    run_op(4'd0,  4'd0,  4'd0,  1'b0, 1'b0);
    run_op(4'd15, 4'd15, 4'd0,  1'b0, 1'b0);
    run_op(4'd0,  4'd1,  4'hF,  1'b1, 1'b0);

    // Result holds after completion.
    repeat (4) @(negedge clk);
    check("hold_diff", 32'(diff), 32'hF);
    check("hold_borrow", 32'(borrow), 32'd1);

    // start held high during RUN must be ignored.
    issue(4'd7, 4'd2, 4'd5, 1'b0, 1'b0);
    a = 4'd1; b = 4'd3; start = 1'b1;
    wait_done();
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("held_start_ignored_busy", 32'(busy), 32'd0);
    check("held_start_done_count", 32'(done_cnt), 32'(exp_done));
    run_op(4'd1, 4'd3, 4'hE, 1'b1, 1'b0);

    // Reset in the 2nd RUN cycle aborts with no done pulse.
    @(negedge clk);
    a = 4'd12; b = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_borrow", 32'(borrow), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'(exp_done));
    run_op(4'd12, 4'd3, 4'd9, 1'b0, 1'b0);

    // Back-to-back pair with borrow toggling.
    run_op(4'd6,  4'd10, 4'hC, 1'b1, 1'b1);
    run_op(4'd10, 4'd6,  4'd4, 1'b0, 1'b1);

    // Signed overflow vectors (ovf checked only when the feature is built).
    run_op(4'd8, 4'd1,  4'd7, 1'b0, 1'b1);
    run_op(4'd3, 4'd2,  4'd1, 1'b0, 1'b0);
    run_op(4'd7, 4'd15, 4'd8, 1'b1, 1'b1);

    repeat (4) @(negedge clk);
    check("total_done_count", 32'(done_cnt), 32'(exp_done));
    check("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
